cache_l2_arbiter: RTL and testbench

CACHE_L2_ARBITER -- requirements
Module: cache_l2_arbiter

---
 rtl/cache_l2_arbiter_if.sv | 53 +++++
 rtl/cache_l2_arbiter.sv | 113 +++++++++++
 tb/tb_cache_l2_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_l2_arbiter_if.sv
// Purpose: bundles the I-side, D-side and L2-side signals of the L2 arbiter
//   into one interface.
// Ports (seen from the arbiter, modport slave):
//   in : inst_read, inst_address, data_read, data_write, data_address,
//        data_wdata, l2_rdata, l2_resp
//   out: inst_rdata, inst_resp, data_rdata, data_resp, l2_read, l2_write,
//        l2_address, l2_wdata, l2_byte_enable, inst_grant_count,
//        data_grant_count
// The master modport is the mirror image, used by whatever drives the L1 and
// L2 sides (the testbench here).
interface cache_l2_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
);
  logic              inst_read;
  logic [31:0]       inst_address;
  logic [LINE_W-1:0] inst_rdata;
  logic              inst_resp;

  logic              data_read;
  logic              data_write;
  logic [31:0]       data_address;
  logic [LINE_W-1:0] data_wdata;
  logic [LINE_W-1:0] data_rdata;
  logic              data_resp;

  logic              l2_read;
  logic              l2_write;
  logic [31:0]       l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [3:0]        l2_byte_enable;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  logic [CNT_W-1:0]  inst_grant_count;
  logic [CNT_W-1:0]  data_grant_count;

  modport slave (
    input  inst_read, inst_address, data_read, data_write, data_address,
           data_wdata, l2_rdata, l2_resp,
    output inst_rdata, inst_resp, data_rdata, data_resp, l2_read, l2_write,
           l2_address, l2_wdata, l2_byte_enable, inst_grant_count,
           data_grant_count
  );

  modport master (
    output inst_read, inst_address, data_read, data_write, data_address,
           data_wdata, l2_rdata, l2_resp,
    input  inst_rdata, inst_resp, data_rdata, data_resp, l2_read, l2_write,
           l2_address, l2_wdata, l2_byte_enable, inst_grant_count,
           data_grant_count
  );
endinterface

// File: rtl/cache_l2_arbiter.sv
// Purpose: arbitrates the instruction-side and data-side L1 miss/write-back
//   requests onto a single L2 port. One request is served at a time; ties are
//   broken round-robin. The granted address/data are latched on the grant and
//   held until the L2 completes, and the L2 completion is forwarded
//   combinationally to the granted side.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - cache_l2_arbiter_if.slave carrying the I-side, D-side, L2-side
//          handshakes and the two saturating grant counters
module cache_l2_arbiter #(
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input logic            clk,
  input logic            rst,
  cache_l2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  logic              last_d;     // 1: D-side had the most recent grant
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic [CNT_W-1:0]  inst_cnt;
  logic [CNT_W-1:0]  data_cnt;

  logic inst_req;
  logic data_req;
  logic pick_i;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + 1'b1;
  endfunction

  assign inst_req = bus.inst_read;
  assign data_req = bus.data_read | bus.data_write;
  // I wins when alone, or on a tie when D was granted last.
  assign pick_i   = inst_req & (~data_req | last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      inst_cnt <= '0;
      data_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_i) begin
            state    <= SERVE_I;
            last_d   <= 1'b0;
            addr_q   <= bus.inst_address;
            rd_q     <= 1'b1;
            wr_q     <= 1'b0;
            inst_cnt <= sat_inc(inst_cnt);
          end else if (data_req) begin
            // read+write together is treated as a write-back
            state    <= SERVE_D;
            last_d   <= 1'b1;
            addr_q   <= bus.data_address;
            wdata_q  <= bus.data_wdata;
            rd_q     <= ~bus.data_write;
            wr_q     <= bus.data_write;
            data_cnt <= sat_inc(data_cnt);
          end
        end
        SERVE_I, SERVE_D: begin
          // Requester drops are ignored; only the L2 ends a transaction.
          if (bus.l2_resp) begin
            state <= IDLE;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
        end
      endcase
    end
  end

  // L2 request side: straight from the registered strobes and latches
  assign bus.l2_read        = rd_q;
  assign bus.l2_write       = wr_q;
  assign bus.l2_address     = addr_q;
  assign bus.l2_wdata       = wdata_q;
  assign bus.l2_byte_enable = 4'b1111;

  // Completion forward: same-cycle pass-through of the L2 response
  assign bus.inst_resp  = (state == SERVE_I) & bus.l2_resp;
  assign bus.data_resp  = (state == SERVE_D) & bus.l2_resp;
  assign bus.inst_rdata = bus.l2_rdata;
  assign bus.data_rdata = bus.l2_rdata;

  assign bus.inst_grant_count = inst_cnt;
  assign bus.data_grant_count = data_cnt;

endmodule

// File: tb/tb_cache_l2_arbiter.sv
// Purpose: self-checking bench for cache_l2_arbiter. A directed table covers
//   the reset state, I-only, tie, stability, ignored responses and
//   mid-transaction reset; hand-written loops cover round-robin order and
//   counter saturation; a random phase compares against a transaction-level
//   reference model. A second instance with CNT_W=2 sees the same stimulus.
// Ports: none (top-level bench).
module tb_cache_l2_arbiter;

  localparam int LW = 256;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cache_l2_arbiter_if #(.LINE_W(LW), .CNT_W(32)) bus ();
  cache_l2_arbiter_if #(.LINE_W(LW), .CNT_W(2))  bus_s ();

  assign bus_s.inst_read    = bus.inst_read;
  assign bus_s.inst_address = bus.inst_address;
  assign bus_s.data_read    = bus.data_read;
  assign bus_s.data_write   = bus.data_write;
  assign bus_s.data_address = bus.data_address;
  assign bus_s.data_wdata   = bus.data_wdata;
  assign bus_s.l2_rdata     = bus.l2_rdata;
  assign bus_s.l2_resp      = bus.l2_resp;

  cache_l2_arbiter #(.LINE_W(LW), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  cache_l2_arbiter #(.LINE_W(LW), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dw;
    logic [31:0] da;
    logic [31:0] wd;
    bit          lr;
    logic [31:0] rd;
    bit          chk;
    bit          e_rd;
    bit          e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    bit          e_ir;
    bit          e_dr;
    int          e_ic;
    int          e_dc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, let combinational outputs settle.
  task automatic drive(input bit r, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [31:0] da,
                       input logic [LW-1:0] wd, input bit lr, input logic [LW-1:0] rd);
    @(negedge clk);
    rst              = r;
    bus.inst_read    = ir;
    bus.inst_address = ia;
    bus.data_read    = dr;
    bus.data_write   = dw;
    bus.data_address = da;
    bus.data_wdata   = wd;
    bus.l2_resp      = lr;
    bus.l2_rdata     = rd;
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 0, 0, 0, 0, 0, '0, 0, '0);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  int            m_own;      // 0 none, 1 I-side transaction open, 2 D-side open
  bit            m_last_d;
  logic [31:0]   m_addr;
  logic [LW-1:0] m_wd;
  bit            m_wr;
  int            m_ic;
  int            m_dc;

  task automatic model_check();
    chk("rnd_l2_read",  LW'(bus.l2_read),  LW'(m_own == 1 || (m_own == 2 && !m_wr)));
    chk("rnd_l2_write", LW'(bus.l2_write), LW'(m_own == 2 && m_wr));
    chk("rnd_l2_addr",  LW'(bus.l2_address), LW'(m_addr));
    chk("rnd_l2_wdata", bus.l2_wdata, m_wd);
    chk("rnd_inst_resp", LW'(bus.inst_resp), LW'(m_own == 1 && bus.l2_resp));
    chk("rnd_data_resp", LW'(bus.data_resp), LW'(m_own == 2 && bus.l2_resp));
    chk("rnd_inst_rdata", bus.inst_rdata, bus.l2_rdata);
    chk("rnd_data_rdata", bus.data_rdata, bus.l2_rdata);
    chk("rnd_icnt", LW'(bus.inst_grant_count), LW'(m_ic));
    chk("rnd_dcnt", LW'(bus.data_grant_count), LW'(m_dc));
    chk("rnd_icnt_sat", LW'(bus_s.inst_grant_count), LW'((m_ic > 3) ? 3 : m_ic));
    chk("rnd_dcnt_sat", LW'(bus_s.data_grant_count), LW'((m_dc > 3) ? 3 : m_dc));
  endtask

  task automatic model_step();
    bit want_i;
    bit want_d;
    want_i = bus.inst_read;
    want_d = bus.data_read || bus.data_write;
    if (rst) begin
      m_own = 0; m_last_d = 1; m_addr = 0; m_wd = '0; m_wr = 0; m_ic = 0; m_dc = 0;
    end else if (m_own != 0) begin
      if (bus.l2_resp) m_own = 0;
    end else if (want_i && (!want_d || m_last_d)) begin
      m_own = 1; m_last_d = 0; m_addr = bus.inst_address; m_ic++;
    end else if (want_d) begin
      m_own = 2; m_last_d = 1; m_addr = bus.data_address; m_wd = bus.data_wdata;
      m_wr = bus.data_write; m_dc++;
    end
  endtask

  initial begin
    int          order[$];
    int          busy;
    int          n;
    bit          lr;
    logic [LW-1:0] rdv;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.inst_read = 0; bus.inst_address = 0; bus.data_read = 0; bus.data_write = 0;
    bus.data_address = 0; bus.data_wdata = '0; bus.l2_resp = 0; bus.l2_rdata = '0;

    //                rst ir ia        dr dw da        wd       lr rd            chk rd wr addr      wd       ir dr ic dc
    vecs.push_back('{1, 0, 0,       0, 0, 0,       0,       0, 0,            0, 0, 0, 0,       0,       0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       0,       0, 0,            1, 0, 0, 0,       0,       0, 0, 0, 0});
    vecs.push_back('{0, 1, 'h1000,  0, 0, 0,       0,       0, 0,            1, 0, 0, 0,       0,       0, 0, 0, 0});
    vecs.push_back('{0, 1, 'h1000,  0, 0, 0,       0,       0, 0,            1, 1, 0, 'h1000,  0,       0, 0, 1, 0});
    vecs.push_back('{0, 1, 'h1000,  0, 0, 0,       0,       0, 0,            1, 1, 0, 'h1000,  0,       0, 0, 1, 0});
    vecs.push_back('{0, 1, 'h1000,  0, 0, 0,       0,       0, 0,            1, 1, 0, 'h1000,  0,       0, 0, 1, 0});
    vecs.push_back('{0, 1, 'h1000,  0, 0, 0,       0,       1, 'hA5A50001,   1, 1, 0, 'h1000,  0,       1, 0, 1, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       0,       0, 0,            1, 0, 0, 'h1000,  0,       0, 0, 1, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       0,       1, 'h1234,       1, 0, 0, 'h1000,  0,       0, 0, 1, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       0,       0, 0,            1, 0, 0, 'h1000,  0,       0, 0, 1, 0});
    vecs.push_back('{1, 0, 0,       0, 0, 0,       0,       0, 0,            0, 0, 0, 0,       0,       0, 0, 0, 0});
    vecs.push_back('{0, 1, 'h4000,  0, 1, 'h5000,  'hDEAD,  0, 0,            1, 0, 0, 0,       0,       0, 0, 0, 0});
    vecs.push_back('{0, 1, 'h4000,  0, 1, 'h5000,  'hDEAD,  0, 0,            1, 1, 0, 'h4000,  0,       0, 0, 1, 0});
    vecs.push_back('{0, 1, 'h4000,  0, 1, 'h5000,  'hDEAD,  1, 'h1111,       1, 1, 0, 'h4000,  0,       1, 0, 1, 0});
    vecs.push_back('{0, 0, 0,       0, 1, 'h5000,  'hDEAD,  0, 0,            1, 0, 0, 'h4000,  0,       0, 0, 1, 0});
    vecs.push_back('{0, 0, 0,       0, 1, 'h5000,  'hDEAD,  0, 0,            1, 0, 1, 'h5000,  'hDEAD,  0, 0, 1, 1});
    vecs.push_back('{0, 0, 0,       0, 1, 'h5000,  'hDEAD,  1, 'h2222,       1, 0, 1, 'h5000,  'hDEAD,  0, 1, 1, 1});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       0,       0, 0,            1, 0, 0, 'h5000,  'hDEAD,  0, 0, 1, 1});
    vecs.push_back('{0, 0, 0,       1, 0, 'h2000,  0,       0, 0,            1, 0, 0, 'h5000,  'hDEAD,  0, 0, 1, 1});
    vecs.push_back('{0, 0, 0,       1, 0, 'h3000,  0,       0, 0,            1, 1, 0, 'h2000,  0,       0, 0, 1, 2});
    vecs.push_back('{0, 0, 0,       0, 0, 'h3000,  0,       0, 0,            1, 1, 0, 'h2000,  0,       0, 0, 1, 2});
    vecs.push_back('{0, 0, 0,       0, 0, 'h3000,  0,       1, 'h3333,       1, 1, 0, 'h2000,  0,       0, 1, 1, 2});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       0,       0, 0,            1, 0, 0, 'h2000,  0,       0, 0, 1, 2});
    vecs.push_back('{0, 0, 0,       1, 1, 'h6000,  'hBEEF,  0, 0,            1, 0, 0, 'h2000,  0,       0, 0, 1, 2});
    vecs.push_back('{0, 0, 0,       1, 1, 'h6000,  'hBEEF,  0, 0,            1, 0, 1, 'h6000,  'hBEEF,  0, 0, 1, 3});
    vecs.push_back('{1, 0, 0,       0, 1, 'h6000,  'hBEEF,  0, 0,            0, 0, 0, 0,       0,       0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       0,       1, 'h4444,       1, 0, 0, 0,       0,       0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,       0, 0, 0,       0,       0, 0,            1, 0, 0, 0,       0,       0, 0, 0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw, vecs[i].da,
            LW'(vecs[i].wd), vecs[i].lr, LW'(vecs[i].rd));
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_l2_read", i),  LW'(bus.l2_read),    LW'(vecs[i].e_rd));
        chk($sformatf("v%0d_l2_write", i), LW'(bus.l2_write),   LW'(vecs[i].e_wr));
        chk($sformatf("v%0d_l2_addr", i),  LW'(bus.l2_address), LW'(vecs[i].e_addr));
        chk($sformatf("v%0d_l2_wdata", i), bus.l2_wdata,        LW'(vecs[i].e_wd));
        chk($sformatf("v%0d_inst_resp", i), LW'(bus.inst_resp), LW'(vecs[i].e_ir));
        chk($sformatf("v%0d_data_resp", i), LW'(bus.data_resp), LW'(vecs[i].e_dr));
        chk($sformatf("v%0d_inst_rdata", i), bus.inst_rdata,    LW'(vecs[i].rd));
        chk($sformatf("v%0d_data_rdata", i), bus.data_rdata,    LW'(vecs[i].rd));
        chk($sformatf("v%0d_byte_en", i),  LW'(bus.l2_byte_enable), LW'(4'hF));
        chk($sformatf("v%0d_icnt", i), LW'(bus.inst_grant_count), LW'(vecs[i].e_ic));
        chk($sformatf("v%0d_dcnt", i), LW'(bus.data_grant_count), LW'(vecs[i].e_dc));
      end
    end

    // Round-robin: both sides request continuously for four transactions.
    drive(1, 0, 0, 0, 0, 0, '0, 0, '0);
    busy = 0;
    for (int c = 0; c < 100 && order.size() < 4; c++) begin
      lr  = (busy >= 2);
      rdv = rand_line();
      drive(0, 1, 'h100, 1, 0, 'h200, '0, lr, rdv);
      if (lr && bus.inst_resp) order.push_back(1);
      if (lr && bus.data_resp) order.push_back(2);
      if (lr) busy = 0;
      else if (bus.l2_read || bus.l2_write) busy++;
      else busy = 0;
    end
    chk("rr_txn_count", LW'(order.size()), LW'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < order.size())
        chk($sformatf("rr_grant%0d", k), LW'(order[k]), LW'((k % 2 == 0) ? 1 : 2));
    end
    idle_cycle();
    chk("rr_icnt", LW'(bus.inst_grant_count), LW'(2));
    chk("rr_dcnt", LW'(bus.data_grant_count), LW'(2));

    // Saturation: five I-side grants against a 2-bit counter.
    drive(1, 0, 0, 0, 0, 0, '0, 0, '0);
    busy = 0;
    n = 0;
    for (int c = 0; c < 200 && n < 5; c++) begin
      lr = (busy >= 1);
      drive(0, 1, 'h300, 0, 0, 0, '0, lr, rand_line());
      if (lr && bus.inst_resp) begin
        n++;
        busy = 0;
      end else if (bus.l2_read) busy++;
      else busy = 0;
    end
    idle_cycle();
    chk("sat_txn_count", LW'(n), LW'(5));
    chk("sat_icnt_wide", LW'(bus.inst_grant_count), LW'(5));
    chk("sat_icnt_2bit", LW'(bus_s.inst_grant_count), LW'(3));
    chk("sat_dcnt_2bit", LW'(bus_s.data_grant_count), LW'(0));

    // Random phase against the reference model.
    m_own = 0; m_last_d = 1; m_addr = 0; m_wd = '0; m_wr = 0; m_ic = 0; m_dc = 0;
    for (int i = 0; i < 3000; i++) begin
      drive((i == 0) || ($urandom_range(0, 199) == 0),
            $urandom_range(0, 99) < 45, $urandom,
            $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 35, $urandom,
            rand_line(), $urandom_range(0, 99) < 30, rand_line());
      if (i != 0) model_check();
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
